// File: rtl/ms_data_arb_pkg.sv
// Shared types and widths for the multi-channel data-bus arbiter family.
package ms_arb_pkg;

  localparam int CAddrW = 32;
  localparam int CDataW = 64;
  localparam int CSizeW = 4;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbBus  = 2'd1,
    ArbAck  = 2'd2
  } arbState_e;

  // Channel index width; a single channel still needs one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ms_data_arb_if.sv
// Requester-side and downstream-bus signals of the arbiter, bundled per instance.
interface ms_data_arb_if
  import ms_arb_pkg::*;
#(
  parameter int CChCnt = 3
) ();

  logic [CChCnt*CAddrW-1:0] AReqAddr;
  logic [CChCnt*CDataW-1:0] AReqMosi;
  logic [CChCnt*CSizeW-1:0] AReqWrSize;
  logic [CChCnt*CSizeW-1:0] AReqRdSize;
  logic [CChCnt-1:0]        AReqLock;
  logic [CChCnt-1:0]        AReqAck;
  logic [CDataW-1:0]        AReqMiso;

  logic [CAddrW-1:0]        ABusAddr;
  logic [CDataW-1:0]        ABusMosi;
  logic [CSizeW-1:0]        ABusWrSize;
  logic [CSizeW-1:0]        ABusRdSize;
  logic [CDataW-1:0]        ABusMiso;
  logic                     ABusBusy;

  logic [CChCnt-1:0]        AGrant;

  modport master (
    input  AReqAddr, AReqMosi, AReqWrSize, AReqRdSize, AReqLock,
    input  ABusMiso, ABusBusy,
    output AReqAck, AReqMiso,
    output ABusAddr, ABusMosi, ABusWrSize, ABusRdSize,
    output AGrant
  );

  modport slave (
    output AReqAddr, AReqMosi, AReqWrSize, AReqRdSize, AReqLock,
    output ABusMiso, ABusBusy,
    input  AReqAck, AReqMiso,
    input  ABusAddr, ABusMosi, ABusWrSize, ABusRdSize,
    input  AGrant
  );

endinterface

// File: rtl/ms_data_arb_rr_pick.sv
// Combinational one-hot picker: round-robin from startIdx, or fixed lowest-index priority.
module ms_rr_pick
  import ms_arb_pkg::*;
#(
  parameter int CChCnt = 3,
  parameter int CIdxW  = idxWidth(CChCnt)
) (
  input  logic [CChCnt-1:0] req,
  input  logic [CIdxW-1:0]  startIdx,
  input  logic              fixedMode,
  output logic [CChCnt-1:0] gnt,
  output logic [CIdxW-1:0]  gntIdx,
  output logic              gntValid
);

  int unsigned idx;

  always_comb begin
    gnt      = '0;
    gntIdx   = '0;
    gntValid = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < CChCnt; k++) begin
      idx = k;
      if (!fixedMode) begin
        idx = idx + 32'(startIdx);
        if (idx >= CChCnt) idx = idx - CChCnt;
      end
      if (!gntValid && req[idx]) begin
        gnt[idx] = 1'b1;
        gntIdx   = CIdxW'(idx);
        gntValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ms_data_arb.sv
// Multi-channel request arbiter forwarding one registered transfer at a time downstream.
module ms_data_arb
  import ms_arb_pkg::*;
#(
  parameter int CChCnt     = 3,
  parameter int CFixedPrio = 0
) (
  input  logic           AClkH,
  input  logic           AResetHN,
  input  logic           AClkHEn,
  ms_data_arb_if.master  arbIf
);

  localparam int               CIdxW    = idxWidth(CChCnt);
  localparam logic [CIdxW-1:0] CLastIdx = CIdxW'(CChCnt - 1);

  arbState_e          state;
  logic [CIdxW-1:0]   rrPtr;
  logic [CIdxW-1:0]   grantIdx;
  logic [CIdxW-1:0]   lockCh;
  logic               lockActive;
  logic [CChCnt-1:0]  grant;
  logic [CChCnt-1:0]  ack;
  logic [CDataW-1:0]  miso;
  logic [CAddrW-1:0]  busAddr;
  logic [CDataW-1:0]  busMosi;
  logic [CSizeW-1:0]  busWr;
  logic [CSizeW-1:0]  busRd;

  logic [CChCnt-1:0]  pend;
  logic [CChCnt-1:0]  lockMask;
  logic [CChCnt-1:0]  pickReq;
  logic [CChCnt-1:0]  pickGnt;
  logic [CIdxW-1:0]   pickIdx;
  logic [CIdxW-1:0]   startIdx;
  logic               pickValid;
  logic               lockEff;

  logic [CAddrW-1:0]  selAddr;
  logic [CDataW-1:0]  selMosi;
  logic [CSizeW-1:0]  selWr;
  logic [CSizeW-1:0]  selRd;

  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < CChCnt; i++) begin
      pend[i] = (|arbIf.AReqWrSize[i*CSizeW +: CSizeW]) |
                (|arbIf.AReqRdSize[i*CSizeW +: CSizeW]);
    end
  end

  // A held lock restricts the search to its owner; it stops holding once the owner
  // is idle with the lock bit low, and the normal search runs in that same cycle.
  always_comb begin
    lockMask         = '0;
    lockMask[lockCh] = 1'b1;
    lockEff  = lockActive && (pend[lockCh] || arbIf.AReqLock[lockCh]);
    pickReq  = lockEff ? (pend & lockMask) : pend;
    startIdx = (rrPtr == CLastIdx) ? '0 : rrPtr + 1'b1;
  end

  ms_rr_pick #(
    .CChCnt (CChCnt),
    .CIdxW  (CIdxW)
  ) uPick (
    .req       (pickReq),
    .startIdx  (startIdx),
    .fixedMode (CFixedPrio != 0),
    .gnt       (pickGnt),
    .gntIdx    (pickIdx),
    .gntValid  (pickValid)
  );

  always_comb begin
    selAddr = arbIf.AReqAddr  [32'(pickIdx)*CAddrW +: CAddrW];
    selMosi = arbIf.AReqMosi  [32'(pickIdx)*CDataW +: CDataW];
    selWr   = arbIf.AReqWrSize[32'(pickIdx)*CSizeW +: CSizeW];
    selRd   = arbIf.AReqRdSize[32'(pickIdx)*CSizeW +: CSizeW];
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      state      <= ArbIdle;
      rrPtr      <= CLastIdx;
      grantIdx   <= '0;
      lockCh     <= '0;
      lockActive <= 1'b0;
      grant      <= '0;
      ack        <= '0;
      miso       <= '0;
      busAddr    <= '0;
      busMosi    <= '0;
      busWr      <= '0;
      busRd      <= '0;
    end else if (AClkHEn) begin
      case (state)
        ArbIdle: begin
          if (lockActive && !lockEff) lockActive <= 1'b0;
          if (pickValid) begin
            state    <= ArbBus;
            grant    <= pickGnt;
            grantIdx <= pickIdx;
            if (CFixedPrio == 0) rrPtr <= pickIdx;
            busAddr  <= selAddr;
            busMosi  <= selMosi;
            busWr    <= selWr;
            busRd    <= selRd;
          end
        end
        ArbBus: begin
          if (!arbIf.ABusBusy) begin
            state   <= ArbAck;
            miso    <= arbIf.ABusMiso;
            ack     <= grant;
            busAddr <= '0;
            busMosi <= '0;
            busWr   <= '0;
            busRd   <= '0;
          end
        end
        ArbAck: begin
          state      <= ArbIdle;
          ack        <= '0;
          grant      <= '0;
          lockActive <= arbIf.AReqLock[grantIdx];
          lockCh     <= grantIdx;
        end
        default: state <= ArbIdle;
      endcase
    end
  end

  assign arbIf.AGrant     = grant;
  assign arbIf.AReqAck    = ack;
  assign arbIf.AReqMiso   = miso;
  assign arbIf.ABusAddr   = busAddr;
  assign arbIf.ABusMosi   = busMosi;
  assign arbIf.ABusWrSize = busWr;
  assign arbIf.ABusRdSize = busRd;

endmodule

// File: tb/tb_ms_data_arb.sv
// Directed bench for ms_data_arb: one round-robin and one fixed-priority instance.
module tb_ms_data_arb;
  import ms_arb_pkg::*;

  logic AClkH = 1'b0;
  logic AResetHN;
  logic AClkHEn;

  always #5 AClkH = ~AClkH;

  ms_data_arb_if #(.CChCnt(3)) rrIf ();
  ms_data_arb_if #(.CChCnt(3)) fpIf ();

  ms_data_arb #(.CChCnt(3), .CFixedPrio(0)) dutRr (
    .AClkH(AClkH), .AResetHN(AResetHN), .AClkHEn(AClkHEn), .arbIf(rrIf.master));

  ms_data_arb #(.CChCnt(3), .CFixedPrio(1)) dutFp (
    .AClkH(AClkH), .AResetHN(AResetHN), .AClkHEn(AClkHEn), .arbIf(fpIf.master));

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [63:0] mosi;
    logic [3:0]  wr;
    logic [3:0]  rd;
    logic [63:0] busMiso;
    int          busy;
    logic [2:0]  expAck;
  } vec_t;

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge AClkH);
    #1;
  endtask

  task automatic clearReqs();
    rrIf.AReqAddr = '0; rrIf.AReqMosi = '0; rrIf.AReqWrSize = '0; rrIf.AReqRdSize = '0;
    rrIf.AReqLock = '0; rrIf.ABusMiso = '0; rrIf.ABusBusy = 1'b0;
    fpIf.AReqAddr = '0; fpIf.AReqMosi = '0; fpIf.AReqWrSize = '0; fpIf.AReqRdSize = '0;
    fpIf.AReqLock = '0; fpIf.ABusMiso = '0; fpIf.ABusBusy = 1'b0;
  endtask

  task automatic setReq(input bit fp, input int ch, input logic [31:0] addr,
                        input logic [63:0] mosi, input logic [3:0] wr, input logic [3:0] rd);
    if (fp) begin
      fpIf.AReqAddr[ch*32 +: 32] = addr;
      fpIf.AReqMosi[ch*64 +: 64] = mosi;
      fpIf.AReqWrSize[ch*4 +: 4] = wr;
      fpIf.AReqRdSize[ch*4 +: 4] = rd;
    end else begin
      rrIf.AReqAddr[ch*32 +: 32] = addr;
      rrIf.AReqMosi[ch*64 +: 64] = mosi;
      rrIf.AReqWrSize[ch*4 +: 4] = wr;
      rrIf.AReqRdSize[ch*4 +: 4] = rd;
    end
  endtask

  task automatic doReset();
    AResetHN = 1'b0;
    step(1);
    AResetHN = 1'b1;
  endtask

  // Bounded wait: a timeout leaves a at zero, so the caller's comparison fails.
  task automatic waitAck(input bit fp, output logic [2:0] a);
    a = '0;
    for (int i = 0; i < 12 && a == '0; i++) begin
      step(1);
      a = fp ? fpIf.AReqAck : rrIf.AReqAck;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  vec_t        vecs [4];
  vec_t        t;
  logic [2:0]  a;
  logic [2:0]  rrOrder [6];

  initial begin
    vecs[0] = '{ch: 1, addr: 32'h0000_0100, mosi: 64'h0, wr: 4'd0, rd: 4'd4,
                busMiso: 64'hDEAD_BEEF_0123_4567, busy: 0, expAck: 3'b010};
    vecs[1] = '{ch: 0, addr: 32'h2000_0004, mosi: 64'hA5A5_0000_FFFF_1234, wr: 4'd8, rd: 4'd0,
                busMiso: 64'h1111_2222_3333_4444, busy: 0, expAck: 3'b001};
    vecs[2] = '{ch: 2, addr: 32'hCAFE_0010, mosi: 64'h0102_0304_0506_0708, wr: 4'd3, rd: 4'd5,
                busMiso: 64'h8877_6655_4433_2211, busy: 2, expAck: 3'b100};
    vecs[3] = '{ch: 1, addr: 32'h0000_0FF8, mosi: 64'hFEDC_BA98_7654_3210, wr: 4'd0, rd: 4'd1,
                busMiso: 64'h0BAD_F00D_0000_0001, busy: 5, expAck: 3'b010};
    rrOrder = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    AClkHEn  = 1'b1;
    AResetHN = 1'b0;
    clearReqs();
    step(2);
    chk("rst grant",   rrIf.AGrant,   '0);
    chk("rst ack",     rrIf.AReqAck,  '0);
    chk("rst miso",    rrIf.AReqMiso, '0);
    chk("rst busaddr", rrIf.ABusAddr, '0);
    chk("rst busmosi", rrIf.ABusMosi, '0);
    chk("rst buswr",   rrIf.ABusWrSize, '0);
    chk("rst busrd",   rrIf.ABusRdSize, '0);
    chk("rst fp grant", fpIf.AGrant,  '0);
    AResetHN = 1'b1;
    step(2);
    chk("idle busaddr", rrIf.ABusAddr, '0);

    // Single transfers; busy is raised already in IDLE, where it must be ignored.
    for (int v = 0; v < 4; v++) begin
      t = vecs[v];
      setReq(1'b0, t.ch, t.addr, t.mosi, t.wr, t.rd);
      rrIf.ABusBusy = (t.busy > 0);
      rrIf.ABusMiso = t.busMiso;
      for (int c = 0; c <= t.busy; c++) begin
        step(1);
        chk($sformatf("v%0d busaddr c%0d", v, c), rrIf.ABusAddr, t.addr);
        chk($sformatf("v%0d busmosi c%0d", v, c), rrIf.ABusMosi, t.mosi);
        chk($sformatf("v%0d buswr c%0d", v, c),   rrIf.ABusWrSize, t.wr);
        chk($sformatf("v%0d busrd c%0d", v, c),   rrIf.ABusRdSize, t.rd);
        chk($sformatf("v%0d grant c%0d", v, c),   rrIf.AGrant, t.expAck);
        chk($sformatf("v%0d noack c%0d", v, c),   rrIf.AReqAck, '0);
        if (c == 0) begin
          rrIf.AReqAddr[t.ch*32 +: 32] = ~t.addr;
          rrIf.AReqMosi[t.ch*64 +: 64] = ~t.mosi;
        end
        if (c == t.busy) rrIf.ABusBusy = 1'b0;
      end
      step(1);
      chk($sformatf("v%0d ack", v),      rrIf.AReqAck,  t.expAck);
      chk($sformatf("v%0d miso", v),     rrIf.AReqMiso, t.busMiso);
      chk($sformatf("v%0d ackbus", v),   rrIf.ABusAddr, '0);
      chk($sformatf("v%0d ackbuswr", v), rrIf.ABusWrSize, '0);
      setReq(1'b0, t.ch, 32'h0, 64'h0, 4'd0, 4'd0);
      rrIf.ABusBusy = 1'b1;
      step(1);
      chk($sformatf("v%0d ackdone", v),  rrIf.AReqAck, '0);
      chk($sformatf("v%0d grantdone", v), rrIf.AGrant, '0);
      rrIf.ABusBusy = 1'b0;
    end

    // Round-robin with all channels requesting continuously.
    doReset();
    for (int ch = 0; ch < 3; ch++) setReq(1'b0, ch, 32'h1000 + 32'(ch), 64'h0, 4'd0, 4'd1);
    for (int k = 0; k < 6; k++) begin
      waitAck(1'b0, a);
      chk($sformatf("rr order %0d", k), a, rrOrder[k]);
      step(1);
      chk($sformatf("rr pulse %0d", k), rrIf.AReqAck, '0);
    end
    clearReqs();

    // Fixed priority: channel 2 starves while channel 0 keeps requesting.
    doReset();
    setReq(1'b1, 0, 32'h40, 64'h0, 4'd2, 4'd0);
    setReq(1'b1, 2, 32'h48, 64'h0, 4'd2, 4'd0);
    for (int k = 0; k < 4; k++) begin
      waitAck(1'b1, a);
      chk($sformatf("fp ch0 %0d", k), a, 3'b001);
      step(1);
    end
    setReq(1'b1, 0, 32'h0, 64'h0, 4'd0, 4'd0);
    waitAck(1'b1, a);
    chk("fp ch2 after drop", a, 3'b100);
    clearReqs();

    // Lock: ch2 keeps the bus for three transfers even though the pointer favours ch0.
    doReset();
    setReq(1'b0, 2, 32'h200, 64'h0, 4'd0, 4'd2);
    rrIf.AReqLock = 3'b100;
    for (int k = 0; k < 3; k++) begin
      waitAck(1'b0, a);
      chk($sformatf("lock ch2 %0d", k), a, 3'b100);
      if (k == 0) setReq(1'b0, 0, 32'h204, 64'h0, 4'd0, 4'd2);
      if (k == 2) rrIf.AReqLock = 3'b000;
    end
    waitAck(1'b0, a);
    chk("lock release ch0", a, 3'b001);
    clearReqs();

    // Clock enable freezes everything, including a pending ack.
    doReset();
    setReq(1'b0, 1, 32'h300, 64'h0, 4'd0, 4'd2);
    rrIf.ABusMiso = 64'h55;
    AClkHEn = 1'b0;
    step(2);
    chk("en0 idle busaddr", rrIf.ABusAddr, '0);
    chk("en0 idle grant",   rrIf.AGrant, '0);
    AClkHEn = 1'b1;
    step(1);
    chk("en1 bus addr", rrIf.ABusAddr, 32'h300);
    AClkHEn = 1'b0;
    step(3);
    chk("en0 bus addr", rrIf.ABusAddr, 32'h300);
    chk("en0 bus noack", rrIf.AReqAck, '0);
    AClkHEn = 1'b1;
    step(1);
    chk("en1 ack", rrIf.AReqAck, 3'b010);
    AClkHEn = 1'b0;
    step(2);
    chk("en0 ack held", rrIf.AReqAck, 3'b010);
    chk("en0 miso held", rrIf.AReqMiso, 64'h55);
    AClkHEn = 1'b1;
    setReq(1'b0, 1, 32'h0, 64'h0, 4'd0, 4'd0);
    step(1);
    chk("en1 ack done", rrIf.AReqAck, '0);

    // Reset in the middle of BUS aborts without an ack.
    setReq(1'b0, 1, 32'h304, 64'h0, 4'd0, 4'd2);
    step(1);
    chk("pre-rst grant", rrIf.AGrant, 3'b010);
    AResetHN = 1'b0;
    #1;
    chk("mid-rst grant", rrIf.AGrant, '0);
    chk("mid-rst busaddr", rrIf.ABusAddr, '0);
    chk("mid-rst busrd", rrIf.ABusRdSize, '0);
    chk("mid-rst miso", rrIf.AReqMiso, '0);
    setReq(1'b0, 1, 32'h0, 64'h0, 4'd0, 4'd0);
    step(1);
    AResetHN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk($sformatf("post-rst noack %0d", k), rrIf.AReqAck, '0);
      chk($sformatf("post-rst grant %0d", k), rrIf.AGrant, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
